// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the execute-issue stage.
//   op_e      - decoded op class presented on in_op
//   state_e   - issue FSM states (also exported on the debug state port)
//   ALU_*     - function codes driven onto alu_f
//   F3_*      - RV64I funct3 values for integer ops and branches
package ex_pkg;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_IMM    = 3'd1,
        OP_LUI    = 3'd2,
        OP_AUIPC  = 3'd3,
        OP_BRANCH = 3'd4,
        OP_JAL    = 3'd5,
        OP_JALR   = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // ALU function codes. ALU_SRA_NEG computes ~((~a) >> sh), which equals an
    // arithmetic right shift whenever a is negative.
    localparam logic [6:0] ALU_AND     = 7'h00;
    localparam logic [6:0] ALU_OR      = 7'h02;
    localparam logic [6:0] ALU_XOR     = 7'h04;
    localparam logic [6:0] ALU_ADD     = 7'h06;
    localparam logic [6:0] ALU_SUB     = 7'h26;
    localparam logic [6:0] ALU_SLL     = 7'h14;
    localparam logic [6:0] ALU_SRL     = 7'h16;
    localparam logic [6:0] ALU_SRA_NEG = 7'h57;

    // Integer op funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/ex_branch_cmp.sv
// ex_branch_cmp: signed/unsigned compare and branch condition select.
// The compare is derived from a subtraction a - b already done in the ALU:
//   a_msb_i, b_msb_i - sign bits of the two operands
//   diff_msb_i       - sign bit of a - b (wrapped)
//   zero_i           - a - b == 0
//   funct3_i         - branch funct3 selecting the condition
//   lt_o / ltu_o     - signed / unsigned a < b
//   taken_o          - branch condition for funct3_i (0 for non-branch codes)
module ex_branch_cmp
    import ex_pkg::*;
(
    input  logic       a_msb_i,
    input  logic       b_msb_i,
    input  logic       diff_msb_i,
    input  logic       zero_i,
    input  logic [2:0] funct3_i,
    output logic       lt_o,
    output logic       ltu_o,
    output logic       taken_o
);

    logic eq;
    logic sign_differs;

    // When the operand signs differ the subtraction may overflow, so the
    // answer comes straight from the operand sign bits instead of the diff.
    assign eq           = zero_i;
    assign sign_differs = a_msb_i ^ b_msb_i;
    assign lt_o         = sign_differs ? a_msb_i : diff_msb_i;
    assign ltu_o        = sign_differs ? b_msb_i : diff_msb_i;

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = eq;
            F3_BNE:  taken_o = ~eq;
            F3_BLT:  taken_o = lt_o;
            F3_BGE:  taken_o = ~lt_o;
            F3_BLTU: taken_o = ltu_o;
            F3_BGEU: taken_o = ~ltu_o;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_issue.sv
// ex_issue: RV64I execute-issue stage wrapped around an external 64-bit ALU.
//   clk, reset_n          - clock, synchronous active-low reset
//   flush                 - drop the in-flight op, return to IDLE
//   in_*                  - decoded op input handshake and operands
//   alu_a/alu_b/alu_f     - ALU operands and function (combinational, registered sources)
//   alu_y/alu_zero        - ALU result, consumed at the end of each pass
//   out_*                 - writeback handshake: result, rd, write enable
//   redirect_valid/_pc    - taken branch or jump target
//   dbg_state_o           - current FSM state (state_e encoding)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, out_valid and all out_*/redirect_* values stay
// stable until that transfer (or a flush/reset). in_ready never depends on
// in_valid; out_valid never depends on out_ready.
module ex_issue
    import ex_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RD_W-1:0] in_rd,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [6:0]      alu_f,
    input  logic [XLEN-1:0] alu_y,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_wen,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      dbg_state_o
);

    state_e          state_q, state_d;

    // Latched op
    op_e             op_q;
    logic [2:0]      funct3_q;
    logic            f7b5_q;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
    logic [RD_W-1:0] rd_q;

    // Results presented in DONE
    logic [XLEN-1:0] result_q, result_d;
    logic            wen_q, wen_d;
    logic            redir_q, redir_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    // First-pass ALU drive
    logic [XLEN-1:0] b_raw;
    logic [XLEN-1:0] shamt;
    logic [XLEN-1:0] p1_a, p1_b;
    logic [6:0]      p1_f;

    logic            accept;
    logic            lt, ltu, taken;
    logic [XLEN-1:0] pc_plus4;

    assign accept      = in_valid & in_ready;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign dbg_state_o = state_q;

    // ---------------------------------------------------------------
    // First-pass operand/function decode
    // ---------------------------------------------------------------
    assign b_raw = (op_q == OP_ALU) ? rs2_q : imm_q;
    // The ALU shifts by the full b value, so only the 6-bit shamt is passed.
    assign shamt = {{(XLEN-6){1'b0}}, b_raw[5:0]};

    always_comb begin
        p1_a = rs1_q;
        p1_b = b_raw;
        p1_f = ALU_ADD;
        case (op_q)
            OP_ALU, OP_IMM: begin
                case (funct3_q)
                    F3_ADD:  p1_f = (op_q == OP_ALU && f7b5_q) ? ALU_SUB : ALU_ADD;
                    F3_SLL: begin
                        p1_f = ALU_SLL;
                        p1_b = shamt;
                    end
                    // SLT/SLTU subtract and fix up the sign afterwards
                    F3_SLT, F3_SLTU: p1_f = ALU_SUB;
                    F3_XOR:  p1_f = ALU_XOR;
                    F3_SR: begin
                        p1_b = shamt;
                        // A logical shift already is the arithmetic shift of a
                        // non-negative value, so SRA only needs its own code when
                        // the sign bit is set.
                        if (f7b5_q && rs1_q[XLEN-1]) p1_f = ALU_SRA_NEG;
                        else                         p1_f = ALU_SRL;
                    end
                    F3_OR:   p1_f = ALU_OR;
                    default: p1_f = ALU_AND;
                endcase
            end
            OP_LUI:    p1_a = '0;
            OP_AUIPC:  p1_a = pc_q;
            OP_BRANCH: begin
                p1_b = rs2_q;
                p1_f = ALU_SUB;
            end
            OP_JAL:    p1_a = pc_q;
            default:   ; // JALR: rs1 + imm
        endcase
    end

    ex_branch_cmp u_branch_cmp (
        .a_msb_i    (p1_a[XLEN-1]),
        .b_msb_i    (p1_b[XLEN-1]),
        .diff_msb_i (alu_y[XLEN-1]),
        .zero_i     (alu_zero),
        .funct3_i   (funct3_q),
        .lt_o       (lt),
        .ltu_o      (ltu),
        .taken_o    (taken)
    );

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_PASS1;
                S_PASS1: state_d = (op_q == OP_BRANCH && taken) ? S_PASS2 : S_DONE;
                S_PASS2: state_d = S_DONE;
                S_DONE:  if (out_ready) state_d = accept ? S_PASS1 : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_f     = ALU_AND;
        case (state_q)
            S_IDLE:  in_ready = ~flush;
            S_PASS1: begin
                alu_a = p1_a;
                alu_b = p1_b;
                alu_f = p1_f;
            end
            S_PASS2: begin
                alu_a = pc_q;
                alu_b = imm_q;
                alu_f = ALU_ADD;
            end
            S_DONE: begin
                out_valid = 1'b1;
                // Accepting while the result leaves keeps back-to-back ops bubble-free
                in_ready  = out_ready & ~flush;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Result fix-up at the end of PASS1
    // ---------------------------------------------------------------
    always_comb begin
        result_d = alu_y;
        wen_d    = (rd_q != '0);
        redir_d  = 1'b0;
        rpc_d    = '0;
        case (op_q)
            OP_ALU, OP_IMM: begin
                if (funct3_q == F3_SLT)       result_d = {{(XLEN-1){1'b0}}, lt};
                else if (funct3_q == F3_SLTU) result_d = {{(XLEN-1){1'b0}}, ltu};
            end
            OP_BRANCH: begin
                // Taken branches get their redirect in PASS2
                result_d = '0;
                wen_d    = 1'b0;
            end
            OP_JAL: begin
                result_d = pc_plus4;
                redir_d  = 1'b1;
                rpc_d    = alu_y;
            end
            OP_JALR: begin
                result_d = pc_plus4;
                redir_d  = 1'b1;
                rpc_d    = {alu_y[XLEN-1:1], 1'b0};
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q     <= OP_ALU;
            funct3_q <= '0;
            f7b5_q   <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            wen_q    <= 1'b0;
            redir_q  <= 1'b0;
            rpc_q    <= '0;
        end else begin
            if (accept) begin
                op_q     <= op_e'(in_op);
                funct3_q <= in_funct3;
                f7b5_q   <= in_funct7b5;
                rs1_q    <= in_rs1;
                rs2_q    <= in_rs2;
                imm_q    <= in_imm;
                pc_q     <= in_pc;
                rd_q     <= in_rd;
            end
            if (state_q == S_PASS1) begin
                result_q <= result_d;
                wen_q    <= wen_d;
                redir_q  <= redir_d;
                rpc_q    <= rpc_d;
            end
            if (state_q == S_PASS2) begin
                redir_q <= 1'b1;
                rpc_q   <= alu_y;
            end
        end
    end

    assign out_result     = result_q;
    assign out_rd         = rd_q;
    // Qualified so that stale register contents never show outside DONE
    assign out_wen        = out_valid & wen_q;
    assign redirect_valid = out_valid & redir_q;
    assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_ex_issue.sv
// tb_ex_issue: bench for ex_issue with a behavioural ALU and an RV64I
// reference model computed from the instruction semantics.
module tb_ex_issue;

    localparam int XLEN = 64;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_op = '0;
    logic [2:0]      in_funct3 = '0;
    logic            in_funct7b5 = 1'b0;
    logic [XLEN-1:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0, in_pc = '0;
    logic [RD_W-1:0] in_rd = '0;
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic [6:0]      alu_f;
    logic            alu_zero;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_wen;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [2:0] br_f3 [0:5] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] one_pass_ops [0:5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    ex_issue #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_y(alu_y), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_rd(out_rd), .out_wen(out_wen),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dbg_state_o(dbg_state)
    );

    // ---------------- behavioural ALU ----------------
    always_comb begin
        case (alu_f)
            7'h00:   alu_y = alu_a & alu_b;
            7'h02:   alu_y = alu_a | alu_b;
            7'h04:   alu_y = alu_a ^ alu_b;
            7'h06:   alu_y = alu_a + alu_b;
            7'h26:   alu_y = alu_a - alu_b;
            7'h14:   alu_y = alu_a << alu_b[5:0];
            7'h16:   alu_y = alu_a >> alu_b[5:0];
            7'h57:   alu_y = ~((~alu_a) >> alu_b[5:0]);
            default: alu_y = 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
        alu_zero = (alu_y == '0);
    end

    // ---------------- reference model ----------------
    task automatic ref_model(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                             input logic [63:0] rs1, input logic [63:0] rs2,
                             input logic [63:0] imm, input logic [63:0] pc, input logic [4:0] rd,
                             output logic [63:0] res, output logic wen, output logic rv,
                             output logic [63:0] rpc, output int lat);
        logic [63:0] b;
        int sh;
        res = '0; wen = (rd != 5'd0); rv = 1'b0; rpc = '0; lat = 2;
        case (op)
            3'd0, 3'd1: begin
                b = (op == 3'd0) ? rs2 : imm;
                sh = int'(b[5:0]);
                case (f3)
                    3'd0: res = (op == 3'd0 && f7) ? rs1 - b : rs1 + b;
                    3'd1: res = rs1 << sh;
                    3'd2: res = ($signed(rs1) < $signed(b)) ? 64'd1 : 64'd0;
                    3'd3: res = (rs1 < b) ? 64'd1 : 64'd0;
                    3'd4: res = rs1 ^ b;
                    3'd5: res = f7 ? ($signed(rs1) >>> sh) : (rs1 >> sh);
                    3'd6: res = rs1 | b;
                    default: res = rs1 & b;
                endcase
            end
            3'd2: res = imm;
            3'd3: res = pc + imm;
            3'd4: begin
                wen = 1'b0;
                case (f3)
                    3'd0: rv = (rs1 == rs2);
                    3'd1: rv = (rs1 != rs2);
                    3'd4: rv = ($signed(rs1) < $signed(rs2));
                    3'd5: rv = ($signed(rs1) >= $signed(rs2));
                    3'd6: rv = (rs1 < rs2);
                    3'd7: rv = (rs1 >= rs2);
                    default: rv = 1'b0;
                endcase
                if (rv) begin rpc = pc + imm; lat = 3; end
            end
            3'd5: begin rv = 1'b1; rpc = pc + imm; res = pc + 64'd4; end
            default: begin rv = 1'b1; rpc = (rs1 + imm) & ~64'd1; res = pc + 64'd4; end
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 20));
            2:       return 64'd0 - 64'($urandom_range(1, 20));
            default: return {32'h8000_0000 | 32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic gen_op(input bit one_pass, output logic [2:0] op, output logic [2:0] f3,
                          output logic f7, output logic [63:0] rs1, output logic [63:0] rs2,
                          output logic [63:0] imm, output logic [63:0] pc, output logic [4:0] rd);
        op  = one_pass ? one_pass_ops[$urandom_range(0, 5)] : 3'($urandom_range(0, 6));
        f3  = (op == 3'd4) ? br_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
        f7  = 1'($urandom_range(0, 1));
        rs1 = rand64();
        rs2 = ($urandom_range(0, 3) == 0) ? rs1 : rand64();
        imm = rand64();
        pc  = {32'($urandom), 32'($urandom) & 32'hFFFF_FFFC};
        rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    endtask

    task automatic set_inputs(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                              input logic [63:0] rs1, input logic [63:0] rs2,
                              input logic [63:0] imm, input logic [63:0] pc, input logic [4:0] rd);
        in_op = op; in_funct3 = f3; in_funct7b5 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
    endtask

    // Presents one op for a single edge; caller guarantees in_ready.
    task automatic issue(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                         input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic [63:0] pc, input logic [4:0] rd);
        set_inputs(op, f3, f7, rs1, rs2, imm, pc, rd);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Issues an op, waits (bounded) for out_valid with out_ready high and
    // returns what was observed. lat counts cycles after the handshake cycle.
    task automatic drive_op(input logic [2:0] op, input logic [2:0] f3, input logic f7,
                            input logic [63:0] rs1, input logic [63:0] rs2,
                            input logic [63:0] imm, input logic [63:0] pc, input logic [4:0] rd,
                            output int lat, output logic [6:0] f_p1, output logic [63:0] res,
                            output logic [4:0] ord, output logic wen, output logic rv,
                            output logic [63:0] rpc);
        out_ready = 1'b1;
        issue(op, f3, f7, rs1, rs2, imm, pc, rd);
        f_p1 = alu_f;
        lat = -1; res = '0; ord = '0; wen = 1'b0; rv = 1'b0; rpc = '0;
        for (int c = 1; c <= 8; c++) begin
            if (out_valid) begin
                lat = c; res = out_result; ord = out_rd; wen = out_wen;
                rv = redirect_valid; rpc = redirect_pc;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_wen !== 1'b0) $display("FAIL reset_out_wen: got %b want 0", out_wen); else pass_cnt++;
        total_cnt++; if (redirect_valid !== 1'b0) $display("FAIL reset_redirect: got %b want 0", redirect_valid); else pass_cnt++;
        total_cnt++; if (alu_f !== 7'h00) $display("FAIL reset_alu_f: got %h want 00", alu_f); else pass_cnt++;
        total_cnt++; if (out_result !== 64'd0) $display("FAIL reset_result: got %h want 0", out_result); else pass_cnt++;
        total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
        reset_n = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int lat; logic [6:0] f; logic [63:0] res, rpc; logic [4:0] ord; logic wen, rv;
        // SUB 5 - 7
        drive_op(3'd0, 3'd0, 1'b1, 64'd5, 64'd7, 64'd0, 64'd0, 5'd3, lat, f, res, ord, wen, rv, rpc);
        total_cnt++; if (f !== 7'h26) $display("FAIL sub_alu_f: got %h want 26", f); else pass_cnt++;
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) $display("FAIL sub_result: got %h want fffffffffffffffe", res); else pass_cnt++;
        total_cnt++; if (lat !== 2) $display("FAIL sub_latency: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (wen !== 1'b1 || ord !== 5'd3) $display("FAIL sub_wen_rd: got %b/%0d want 1/3", wen, ord); else pass_cnt++;
        // SRAI negative
        drive_op(3'd1, 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FF00, 64'd0, 64'd4, 64'd0, 5'd7, lat, f, res, ord, wen, rv, rpc);
        total_cnt++; if (f !== 7'h57) $display("FAIL srai_neg_alu_f: got %h want 57", f); else pass_cnt++;
        total_cnt++; if (res !== 64'hFFFF_FFFF_FFFF_FFF0) $display("FAIL srai_neg_result: got %h want fffffffffffffff0", res); else pass_cnt++;
        // SRAI positive
        drive_op(3'd1, 3'd5, 1'b1, 64'h100, 64'd0, 64'd4, 64'd0, 5'd7, lat, f, res, ord, wen, rv, rpc);
        total_cnt++; if (f !== 7'h16) $display("FAIL srai_pos_alu_f: got %h want 16", f); else pass_cnt++;
        total_cnt++; if (res !== 64'h10) $display("FAIL srai_pos_result: got %h want 10", res); else pass_cnt++;
        // SLT -1 < 1
        drive_op(3'd0, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd4, lat, f, res, ord, wen, rv, rpc);
        total_cnt++; if (res !== 64'd1) $display("FAIL slt_result: got %h want 1", res); else pass_cnt++;
        // SLTU same operands, rd = 0
        drive_op(3'd0, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd0, lat, f, res, ord, wen, rv, rpc);
        total_cnt++; if (res !== 64'd0) $display("FAIL sltu_result: got %h want 0", res); else pass_cnt++;
        total_cnt++; if (wen !== 1'b0) $display("FAIL sltu_rd0_wen: got %b want 0", wen); else pass_cnt++;
        // BLT taken
        drive_op(3'd4, 3'd4, 1'b0, 64'd0 - 64'd3, 64'd2, 64'h20, 64'h1000, 5'd9, lat, f, res, ord, wen, rv, rpc);
        total_cnt++; if (lat !== 3) $display("FAIL blt_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (rv !== 1'b1 || rpc !== 64'h1020) $display("FAIL blt_redirect: got %b/%h want 1/1020", rv, rpc); else pass_cnt++;
        total_cnt++; if (wen !== 1'b0) $display("FAIL blt_wen: got %b want 0", wen); else pass_cnt++;
        // BGE not taken
        drive_op(3'd4, 3'd5, 1'b0, 64'd0 - 64'd3, 64'd2, 64'h20, 64'h1000, 5'd9, lat, f, res, ord, wen, rv, rpc);
        total_cnt++; if (lat !== 2) $display("FAIL bge_latency: got %0d want 2", lat); else pass_cnt++;
        total_cnt++; if (rv !== 1'b0) $display("FAIL bge_redirect: got %b want 0", rv); else pass_cnt++;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        issue(3'd6, 3'd0, 1'b0, 64'h2003, 64'd0, 64'd4, 64'h400, 5'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid); else pass_cnt++;
            total_cnt++; if (out_result !== 64'h404) $display("FAIL stall_result[%0d]: got %h want 404", i, out_result); else pass_cnt++;
            total_cnt++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h2006) $display("FAIL stall_redirect[%0d]: got %b/%h want 1/2006", i, redirect_valid, redirect_pc); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); else pass_cnt++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        // flush in PASS1
        issue(3'd0, 3'd0, 1'b0, 64'd1, 64'd2, 64'd0, 64'd0, 5'd2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total_cnt++; if (dbg_state !== 2'd0) $display("FAIL flush_p1_state: got %0d want 0", dbg_state); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_p1_valid[%0d]: got %b want 0", i, out_valid); else pass_cnt++;
            @(posedge clk); #1;
        end
        // flush together with in_valid in IDLE
        set_inputs(3'd2, 3'd0, 1'b0, 64'd0, 64'd0, 64'h55, 64'd0, 5'd5);
        in_valid = 1'b1; flush = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_idle_ready: got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_idle_valid[%0d]: got %b want 0", i, out_valid); else pass_cnt++;
            @(posedge clk); #1;
        end
        // flush in DONE wins over out_ready and blocks a new op
        issue(3'd2, 3'd0, 1'b0, 64'd0, 64'd0, 64'h77, 64'd0, 5'd5);
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b1) $display("FAIL flush_done_pre: got %b want 1", out_valid); else pass_cnt++;
        in_valid = 1'b1; flush = 1'b1;
        #1;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_done_ready: got %b want 0", in_ready); else pass_cnt++;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        total_cnt++; if (out_valid !== 1'b0 || dbg_state !== 2'd0) $display("FAIL flush_done_post: got %b/%0d want 0/0", out_valid, dbg_state); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_done_noissue: got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        issue(3'd5, 3'd0, 1'b0, 64'd0, 64'd0, 64'h100, 64'h800, 5'd1);
        reset_n = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (out_valid !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL reset_mid[%0d]: got %b/%b want 0/0", i, out_valid, redirect_valid); else pass_cnt++;
            @(posedge clk); #1;
        end
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [2:0] op, f3; logic f7; logic [63:0] rs1, rs2, imm, pc; logic [4:0] rd;
        logic [63:0] e_res, e_rpc, res, rpc; logic e_wen, e_rv, wen, rv; int e_lat, lat;
        logic [6:0] f; logic [4:0] ord;
        for (int n = 0; n < 60; n++) begin
            gen_op(1'b0, op, f3, f7, rs1, rs2, imm, pc, rd);
            ref_model(op, f3, f7, rs1, rs2, imm, pc, rd, e_res, e_wen, e_rv, e_rpc, e_lat);
            drive_op(op, f3, f7, rs1, rs2, imm, pc, rd, lat, f, res, ord, wen, rv, rpc);
            total_cnt++; if (lat !== e_lat) $display("FAIL rnd%0d_latency op=%0d f3=%0d: got %0d want %0d", n, op, f3, lat, e_lat); else pass_cnt++;
            total_cnt++; if (wen !== e_wen || ord !== rd) $display("FAIL rnd%0d_wen_rd: got %b/%0d want %b/%0d", n, wen, ord, e_wen, rd); else pass_cnt++;
            total_cnt++; if (rv !== e_rv) $display("FAIL rnd%0d_redirect op=%0d f3=%0d: got %b want %b", n, op, f3, rv, e_rv); else pass_cnt++;
            if (op != 3'd4) begin
                total_cnt++; if (res !== e_res) $display("FAIL rnd%0d_result op=%0d f3=%0d f7=%b a=%h b=%h imm=%h: got %h want %h", n, op, f3, f7, rs1, rs2, imm, res, e_res); else pass_cnt++;
            end
            if (e_rv) begin
                total_cnt++; if (rpc !== e_rpc) $display("FAIL rnd%0d_redirect_pc: got %h want %h", n, rpc, e_rpc); else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [2:0] op, f3; logic f7; logic [63:0] rs1, rs2, imm, pc; logic [4:0] rd;
        logic [63:0] e_res, e_rpc, e; logic e_wen, e_rv, acc; int e_lat;
        int k, sent, got;
        k = 8; sent = 0; got = 0;
        out_ready = 1'b1;
        gen_op(1'b1, op, f3, f7, rs1, rs2, imm, pc, rd);
        ref_model(op, f3, f7, rs1, rs2, imm, pc, rd, e_res, e_wen, e_rv, e_rpc, e_lat);
        exp_q.push_back(e_res);
        set_inputs(op, f3, f7, rs1, rs2, imm, pc, rd);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got < k; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    total_cnt++; $display("FAIL b2b_extra_output: got result %h want none", out_result);
                end else begin
                    e = exp_q.pop_front();
                    total_cnt++; if (out_result !== e) $display("FAIL b2b_result[%0d]: got %h want %h", got, out_result, e); else pass_cnt++;
                    total_cnt++; if (cyc !== 2 * got + 2) $display("FAIL b2b_cycle[%0d]: got %0d want %0d", got, cyc, 2 * got + 2); else pass_cnt++;
                end
                got++;
            end
            acc = in_valid & in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < k) begin
                    gen_op(1'b1, op, f3, f7, rs1, rs2, imm, pc, rd);
                    ref_model(op, f3, f7, rs1, rs2, imm, pc, rd, e_res, e_wen, e_rv, e_rpc, e_lat);
                    exp_q.push_back(e_res);
                    set_inputs(op, f3, f7, rs1, rs2, imm, pc, rd);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        total_cnt++; if (got !== k) $display("FAIL b2b_count: got %0d want %0d", got, k); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ex_issue.md
Name: ex_issue

Overview:
- Execute-issue stage that sits directly upstream of the 64-bit ALU and also consumes its result.
- Accepts one decoded RV64I integer instruction through a valid/ready handshake and registers its operands.
- Drives the ALU a/b/f inputs for one or two passes, applies result fix-ups, and resolves branches and jumps.
- Presents the writeback result plus any redirect to the next stage through a second valid/ready handshake.

Parameters:
XLEN, 64, datapath width; must equal the ALU width.
RD_W, 5, destination register index width.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset_n  in  1  synchronous, active-low reset.
flush  in  1  discard the in-flight op.
in_valid  in  1  upstream op valid.
in_ready  out  1  stage can accept an op.
in_op  in  3  op class: ALU=0, IMM=1, LUI=2, AUIPC=3, BRANCH=4, JAL=5, JALR=6.
in_funct3  in  3  RISC-V funct3.
in_funct7b5  in  1  funct7 bit 5 (SUB/SRA select).
in_rs1  in  XLEN  rs1 value.
in_rs2  in  XLEN  rs2 value.
in_imm  in  XLEN  sign-extended immediate.
in_pc  in  XLEN  instruction PC.
in_rd  in  RD_W  destination register.
alu_a  out  XLEN  ALU operand a.
alu_b  out  XLEN  ALU operand b.
alu_f  out  7  ALU function code.
alu_y  in  XLEN  ALU result (combinational from alu_a/b/f).
alu_zero  in  1  ALU result == 0.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts.
out_result  out  XLEN  writeback value.
out_rd  out  RD_W  destination register.
out_wen  out  1  write enable; 0 when rd == 0 or the op is BRANCH.
redirect_valid  out  1  taken branch or jump.
redirect_pc  out  XLEN  redirect target.

Behaviour:
- Reset (reset_n low at an edge):
  - state = IDLE; all registers 0.
  - out_valid, out_wen and redirect_valid are 0; alu_f = 0x00.
  - in_ready = 1 from the first cycle after reset deasserts.
- States:
  - IDLE: in_ready = 1.
  - PASS1: first ALU evaluation.
  - PASS2: branch target calculation only.
  - DONE: out_valid = 1; all out_* held stable until out_ready.
- Acceptance: in_valid & in_ready at an edge latches the op and moves to PASS1.
  - In DONE, in_ready = out_ready & ~flush, so back-to-back ops issue without a bubble.
- The ALU is driven combinationally from registered operands; alu_y is captured at the end of each pass.
- ALU function codes used:
  - AND 0x00, OR 0x02, XOR 0x04, ADD 0x06, SUB 0x26, SLL 0x14, SRL 0x16.
  - SRA 0x57 when a[63]=1 (computes ~((~a)>>sh)); SRA 0x16 when a[63]=0.
  - No other codes are issued.
- Operand b for shifts is {58'b0, b[5:0]}.
- ALU and IMM ops: one pass, b = rs2 (ALU) or imm (IMM). SUB only for ALU op with funct7b5 = 1.
  - SLT/SLTU: pass SUB, then fix up locally with d = alu_y[63]:
    - slt = (a63 != b63) ? a63 : d
    - sltu = (a63 != b63) ? b63 : d
    - result = {63'b0, flag}
- LUI: a = 0, b = imm, ADD. AUIPC: a = pc, b = imm, ADD.
- BRANCH:
  - PASS1: SUB rs1 - rs2; eq = alu_zero; lt/ltu as above.
  - Condition by funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.
  - Taken: PASS2 computes ADD pc + imm, redirect_valid = 1.
  - Not taken: go straight to DONE with redirect_valid = 0.
- JAL: PASS1 ADD pc + imm is the target. JALR: PASS1 ADD rs1 + imm with bit 0 cleared is the target.
  - Both: result = pc + 4 from a local incrementer; redirect_valid = 1.
- Latency from the handshake cycle N: out_valid in cycle N+2 for one-pass ops, N+3 for taken branches.
- Flush:
  - Any state returns to IDLE on the next edge; out_valid drops.
  - A flush in the same cycle as in_valid is not accepted (in_ready is masked).
  - Flush has priority over out_ready.
- Reset mid-operation: the op is discarded with no output; reset has priority over flush.
- Arithmetic wraps modulo 2^64; no overflow indication.

Decomposition:
- Package ex_pkg holds:
  - op-class enum and state enum;
  - ALU code constants: ALU_AND, ALU_OR, ALU_XOR, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA_NEG;
  - branch funct3 constants.
- One natural sub-module, ex_branch_cmp: combinational eq/lt/ltu plus funct3 condition select from (a63, b63, alu_y[63], alu_zero).

Test Plan:
- ALU SUB, rs1=5, rs2=7 -> alu_f=0x26; out_result=0xFFFF_FFFF_FFFF_FFFE; out_valid in cycle N+2.
- IMM SRAI, rs1=0xFFFF_FFFF_FFFF_FF00, imm=4 -> alu_f=0x57; out_result=0xFFFF_FFFF_FFFF_FFF0. Same with rs1=0x100 -> 0x10.
- SLT rs1=-1, rs2=1 -> 1; SLTU same operands -> 0; rd=0 -> out_wen=0.
- BLT rs1=-3, rs2=2, pc=0x1000, imm=0x20 -> redirect_pc=0x1020, out_valid in N+3; BGE same operands -> redirect_valid=0 at N+2.
- JALR rs1=0x2003, imm=4, pc=0x400 -> redirect_pc=0x2006, out_result=0x404; out_ready held low 3 cycles -> outputs stable, in_ready=0.
- Flush asserted in PASS1 -> IDLE next cycle, no out_valid. Flush together with in_valid -> op not accepted.
